shift_seq_unit: RTL and testbench

//  Multi-cycle iterative shift unit for the RV32I execute path: SLL/SRL/SRA (rs1 by shamt).

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_step.sv | 33 +++
 rtl/shift_seq_unit.sv | 93 +++++++++
 tb/tb_shift_seq_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared types for the sequential shift unit
// Contents:
//   shift_op_e  - operation encoding (SLL/SRL/ROR/SRA)
//   seq_state_e - sequencer states (IDLE/SHIFT/DONE)
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_ROR = 2'b10,
        SH_SRA = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational shift of an accumulator by 0..STEP bits
// Ports:
//   i_acc - value to shift
//   i_amt - bits to shift this cycle (0..STEP)
//   i_op  - operation; SRA fills with i_acc[XLEN-1], SLL/SRL fill zeros
//   o_res - shifted value
// Macro SHIFT_SEQ_ROR_EN: when defined op 10 rotates right, otherwise it acts as SRL.
module shift_step
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1,
    localparam int AW  = $clog2(STEP + 1)
) (
    input  logic [XLEN-1:0] i_acc,
    input  logic [AW-1:0]   i_amt,
    input  shift_op_e       i_op,
    output logic [XLEN-1:0] o_res
);

    always_comb begin
        o_res = i_acc;
        for (int k = 1; k <= STEP; k++)
            if (i_amt == AW'(k))
                o_res = i_op == SH_SLL ? i_acc << k
                      : i_op == SH_SRA ? (i_acc >> k) | (~({XLEN{1'b1}} >> k) & {XLEN{i_acc[XLEN-1]}})
`ifdef SHIFT_SEQ_ROR_EN
                      : i_op == SH_ROR ? (i_acc >> k) | (i_acc << (XLEN - k))
`endif
                      : i_acc >> k;
    end

endmodule

// File: rtl/shift_seq_unit.sv
// shift_seq_unit: multi-cycle iterative SLL/SRL/SRA shifter, at most STEP bits per cycle
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   flush                   - synchronous abort of any in-flight op
//   in_valid/in_ready       - operation handshake (data_in, shift_amount, shift_op)
//   out_valid/out_ready     - result handshake (data_out)
//   busy                    - unit not idle
// Macro SHIFT_SEQ_ROR_EN: when defined op 10 is rotate right, otherwise SRL.
module shift_seq_unit
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] data_in,
    input  logic [SHW-1:0]  shift_amount,
    input  logic [1:0]      shift_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] data_out,
    output logic            busy
);

    localparam int AW = $clog2(STEP + 1);

    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
        $error("shift_seq_unit: STEP must be 1, 2, 4 or 8");
    end

    seq_state_e      r_state;
    logic [XLEN-1:0] r_acc;
    logic [SHW-1:0]  r_rem;
    shift_op_e       r_op;

    logic [AW-1:0]   w_amt;
    logic [SHW-1:0]  w_rem_next;
    logic [XLEN-1:0] w_acc_next;

    // Bits shifted this cycle: min(STEP, remaining)
    assign w_amt      = (r_rem > SHW'(STEP)) ? AW'(STEP) : AW'(r_rem);
    assign w_rem_next = r_rem - SHW'(w_amt);

    shift_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
        .i_acc (r_acc),
        .i_amt (w_amt),
        .i_op  (r_op),
        .o_res (w_acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_op    <= SH_SLL;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:
                    if (in_valid) begin
                        r_acc   <= data_in;
                        r_rem   <= shift_amount;
                        r_op    <= shift_op_e'(shift_op);
                        r_state <= shift_amount == '0 ? S_DONE : S_SHIFT;
                    end
                S_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_rem <= w_rem_next;
                    if (w_rem_next == '0)
                        r_state <= S_DONE;
                end
                S_DONE:
                    if (out_ready)
                        r_state <= S_IDLE;
                default:
                    r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_state == S_IDLE && !flush;
    assign out_valid = r_state == S_DONE;
    assign busy      = r_state != S_IDLE;
    assign data_out  = r_acc;

endmodule

// File: tb/tb_shift_seq_unit.sv
// tb_shift_seq_unit: directed self-checking bench for shift_seq_unit (STEP=1 and STEP=4 instances)
module tb_shift_seq_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid4 = 1'b0;
    logic [31:0] data_in = '0;
    logic [4:0]  shift_amount = '0;
    logic [1:0]  shift_op = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, busy;
    logic        in_ready4, out_valid4, busy4;
    logic [31:0] data_out, data_out4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_seq_unit #(.XLEN(32), .STEP(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .shift_amount(shift_amount), .shift_op(shift_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .busy(busy)
    );

    shift_seq_unit #(.XLEN(32), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .data_in(data_in), .shift_amount(shift_amount), .shift_op(shift_op),
        .out_valid(out_valid4), .out_ready(out_ready),
        .data_out(data_out4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one op, returns edges after the accept edge until out_valid (-1 on timeout) and the result
    task automatic run_op(input bit d4, input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                          output int cyc, output logic [31:0] res);
        int g = 0;
        while (!(d4 ? in_ready4 : in_ready) && g < 50) begin
            tick();
            g++;
        end
        data_in = d;
        shift_amount = sh;
        shift_op = op;
        if (d4) in_valid4 = 1'b1;
        else in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_valid4 = 1'b0;
        data_in = 32'hDEAD_BEEF;
        shift_amount = 5'd13;
        shift_op = 2'b11;
        cyc = 0;
        while (!(d4 ? out_valid4 : out_valid) && cyc < 100) begin
            tick();
            cyc++;
        end
        if (cyc >= 100) cyc = -1;
        res = d4 ? data_out4 : data_out;
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks += 4;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (data_out !== 32'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=00000000", data_out); end
    endtask

    task automatic test_srl_long();
        int c;
        logic [31:0] r;
        run_op(1'b0, 32'h8000_0000, 5'd31, 2'b01, c, r);
        checks += 3;
        if (c !== 31) begin failures++; $display("FAIL srl31_latency got=%0d exp=31", c); end
        if (r !== 32'h0000_0001) begin failures++; $display("FAIL srl31_data got=%h exp=00000001", r); end
        if (busy !== 1'b1) begin failures++; $display("FAIL srl31_busy_done got=%b exp=1", busy); end
        take();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL srl31_after_take got=%b exp=0", out_valid); end
    endtask

    task automatic test_sra_sll();
        int c;
        logic [31:0] r;
        run_op(1'b0, 32'h8000_0000, 5'd4, 2'b11, c, r);
        checks += 2;
        if (c !== 4) begin failures++; $display("FAIL sra4_latency got=%0d exp=4", c); end
        if (r !== 32'hF800_0000) begin failures++; $display("FAIL sra4_data got=%h exp=f8000000", r); end
        take();
        run_op(1'b0, 32'h0000_0001, 5'd0, 2'b00, c, r);
        checks += 2;
        if (c !== 0) begin failures++; $display("FAIL sll0_latency got=%0d exp=0", c); end
        if (r !== 32'h0000_0001) begin failures++; $display("FAIL sll0_data got=%h exp=00000001", r); end
        take();
        run_op(1'b0, 32'h0000_0001, 5'd5, 2'b00, c, r);
        checks++;
        if (r !== 32'h0000_0020) begin failures++; $display("FAIL sll5_data got=%h exp=00000020", r); end
        take();
    endtask

    task automatic test_step4();
        int c;
        logic [31:0] r;
        run_op(1'b1, 32'hFFFF_FFFF, 5'd7, 2'b01, c, r);
        checks += 2;
        if (c !== 2) begin failures++; $display("FAIL s4_srl7_latency got=%0d exp=2", c); end
        if (r !== 32'h01FF_FFFF) begin failures++; $display("FAIL s4_srl7_data got=%h exp=01ffffff", r); end
        take();
        run_op(1'b1, 32'h8000_0000, 5'd9, 2'b11, c, r);
        checks += 2;
        if (c !== 3) begin failures++; $display("FAIL s4_sra9_latency got=%0d exp=3", c); end
        if (r !== 32'hFFC0_0000) begin failures++; $display("FAIL s4_sra9_data got=%h exp=ffc00000", r); end
        take();
    endtask

    task automatic test_back_to_back();
        int c;
        logic [31:0] r;
        run_op(1'b0, 32'h0000_0003, 5'd2, 2'b00, c, r);
        checks++;
        if (r !== 32'h0000_000C) begin failures++; $display("FAIL bp_data got=%h exp=0000000c", r); end
        in_valid = 1'b1;
        data_in = 32'h1234_5678;
        shift_amount = 5'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks += 3;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
            if (data_out !== 32'h0000_000C) begin failures++; $display("FAIL bp_data_hold cyc=%0d got=%h exp=0000000c", i, data_out); end
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
        end
        in_valid = 1'b0;
        take();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        run_op(1'b0, 32'h0000_00F0, 5'd4, 2'b01, c, r);
        checks += 2;
        if (c !== 4) begin failures++; $display("FAIL b2b_latency got=%0d exp=4", c); end
        if (r !== 32'h0000_000F) begin failures++; $display("FAIL b2b_data got=%h exp=0000000f", r); end
        take();
    endtask

    task automatic test_flush();
        int seen = 0;
        data_in = 32'hFFFF_FFFF;
        shift_amount = 5'd10;
        shift_op = 2'b01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL flush_no_result got=%0d exp=0", seen); end
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_beats_accept got=%b exp=0", busy); end
    endtask

    task automatic test_rst_mid();
        data_in = 32'hFFFF_FFFF;
        shift_amount = 5'd20;
        shift_op = 2'b11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
        if (data_out !== 32'h0) begin failures++; $display("FAIL rst_mid_data got=%h exp=00000000", data_out); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ror();
        int c;
        logic [31:0] r;
        logic [31:0] exp_v;
`ifdef SHIFT_SEQ_ROR_EN
        exp_v = 32'h8000_0000;
`else
        exp_v = 32'h0000_0000;
`endif
        run_op(1'b0, 32'h0000_0001, 5'd1, 2'b10, c, r);
        checks += 2;
        if (c !== 1) begin failures++; $display("FAIL op10_latency got=%0d exp=1", c); end
        if (r !== exp_v) begin failures++; $display("FAIL op10_data got=%h exp=%h", r, exp_v); end
        take();
    endtask

    initial begin
        test_reset();
        test_srl_long();
        test_sra_sll();
        test_step4();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        test_ror();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
